// File: rtl/mem_stage_sram_if.sv
// Bus bundle for the memory stage: EXE/MEM inputs, MEM/WB outputs and the
// 16-bit asynchronous SRAM pins.
interface mem_stage_sram_if;
    logic        WB_en_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic [31:0] ALU_result_in;
    logic [31:0] ST_val_in;
    logic [3:0]  Dest_in;

    logic        WB_en;
    logic        MEM_R_EN;
    logic [31:0] ALU_result;
    logic [31:0] Mem_read_value;
    logic [3:0]  Dest;
    logic        ready;

    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N;

    // The master side is the surrounding pipeline plus the SRAM pad.
    modport master (
        output WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
        output SRAM_DQ_in,
        input  WB_en, MEM_R_EN, ALU_result, Mem_read_value, Dest, ready,
        input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

    modport slave (
        input  WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
        input  SRAM_DQ_in,
        output WB_en, MEM_R_EN, ALU_result, Mem_read_value, Dest, ready,
        output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );
endinterface

// File: rtl/mem_stage_sram.sv
// Pipeline memory stage: 32-bit word loads/stores split into two 16-bit
// half-accesses on an asynchronous SRAM, stalling the pipeline via ready.
module mem_stage_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_sram_if.slave  bus
);
    localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0]   rdata;
    logic [17:0]   addr_hold;
    logic [17:0]   addr_cur;
    logic [31:0]   offset;
    logic [17:0]   addr_lo, addr_hi;
    logic          req, is_write, last, active;
    logic          unused_offset_bits;

    assign req      = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
    assign is_write = bus.MEM_W_EN_in;
    assign offset   = bus.ALU_result_in - BASE_ADDR;
    assign addr_lo  = {offset[18:2], 1'b0};
    assign addr_hi  = {offset[18:2], 1'b1};
    assign last     = (cnt == LAST);
    assign active   = (state == LOW) || (state == HIGH);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (req) begin
                state_next = LOW;
                cnt_next   = '0;
            end
            LOW: if (last) begin
                state_next = HIGH;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + CW'(1);
            end
            HIGH: if (last) begin
                state_next = DONE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + CW'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // WE_N rises on the final cycle of each phase so address and data are held past the strobe.
    always_comb begin
        addr_cur        = addr_hold;
        bus.SRAM_DQ_out = bus.ST_val_in[15:0];
        bus.SRAM_DQ_oe  = 1'b0;
        bus.SRAM_WE_N   = 1'b1;
        if (state == LOW) begin
            addr_cur = addr_lo;
        end else if (state == HIGH) begin
            addr_cur        = addr_hi;
            bus.SRAM_DQ_out = bus.ST_val_in[31:16];
        end
        if (active && is_write) begin
            bus.SRAM_DQ_oe = 1'b1;
            bus.SRAM_WE_N  = last;
        end
    end

    assign bus.SRAM_ADDR = addr_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold <= '0;
            rdata     <= '0;
        end else begin
            if (active) begin
                addr_hold <= addr_cur;
            end
            if (!is_write && last && state == LOW) begin
                rdata[15:0] <= bus.SRAM_DQ_in;
            end
            if (!is_write && last && state == HIGH) begin
                rdata[31:16] <= bus.SRAM_DQ_in;
            end
        end
    end

    assign bus.ready          = !(req && state != DONE);
    assign bus.WB_en          = bus.WB_en_in & bus.ready;
    assign bus.MEM_R_EN       = bus.MEM_R_EN_in;
    assign bus.ALU_result     = bus.ALU_result_in;
    assign bus.Dest           = bus.Dest_in;
    assign bus.Mem_read_value = rdata;
endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage ARM-style pipeline. Sits directly downstream of the EXE/MEM pipeline register and feeds the MEM/WB register.
- Performs 32-bit word loads and stores against an external 16-bit asynchronous SRAM using a multi-cycle controller FSM.
- Drives `ready` low while an access is in flight. The hazard/freeze logic uses it to stall every pipeline register, including EXE/MEM via its `freeze` input.

Parameters:
- BASE_ADDR, 1024: data-memory base; SRAM byte address = ALU_result_in - BASE_ADDR.
- WAIT_CYCLES, 5: cycles each 16-bit SRAM half-access is held (legal range ≥2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- WB_en_in  in  1  write-back enable from EXE/MEM
- MEM_R_EN_in  in  1  load request
- MEM_W_EN_in  in  1  store request
- ALU_result_in  in  32  effective address / ALU result
- ST_val_in  in  32  store data
- Dest_in  in  4  destination register index
- WB_en  out  1  to MEM/WB
- MEM_R_EN  out  1  to MEM/WB (selects load data at write-back)
- ALU_result  out  32  to MEM/WB
- Mem_read_value  out  32  assembled load data
- Dest  out  4  to MEM/WB
- ready  out  1  high = stage may advance; low = freeze pipeline
- SRAM_ADDR  out  18  halfword address
- SRAM_DQ_out  out  16  write data
- SRAM_DQ_oe  out  1  tri-state enable for SRAM_DQ_out (top level builds the inout)
- SRAM_DQ_in  in  16  read data from pad
- SRAM_WE_N  out  1  SRAM write strobe, active-low

Behaviour:
- Pass-through:
  - WB_en, MEM_R_EN, ALU_result and Dest are combinational copies of their _in signals.
  - WB_en is forced to 0 when ready=0, so a stalled load never writes back early.
- Request: req = MEM_R_EN_in | MEM_W_EN_in. If both are high, treat it as a write.
- Addressing:
  - a = ALU_result_in - BASE_ADDR, 32-bit, wraps modulo 2^32.
  - Low half at SRAM_ADDR = {a[18:2],1'b0}; high half at {a[18:2],1'b1}.
  - a[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE. A counter cnt runs 0..WAIT_CYCLES-1 within LOW and within HIGH.
  - IDLE: req → LOW, cnt=0; otherwise stay in IDLE.
  - LOW: SRAM_ADDR = low-half address. When cnt=WAIT_CYCLES-1 → HIGH, cnt=0; otherwise cnt++.
  - HIGH: SRAM_ADDR = high-half address. When cnt=WAIT_CYCLES-1 → DONE.
  - DONE: → IDLE unconditionally, with one cycle.
- Write, per phase:
  - SRAM_DQ_oe=1.
  - SRAM_DQ_out = ST_val_in[15:0] in LOW, ST_val_in[31:16] in HIGH.
  - SRAM_WE_N=0 while cnt<WAIT_CYCLES-1; =1 on the final cycle of the phase (address/data hold).
- Read:
  - SRAM_DQ_oe=0, SRAM_WE_N=1.
  - Register SRAM_DQ_in on the clock edge ending the last cycle of LOW into rdata[15:0], and of HIGH into rdata[31:16].
  - Mem_read_value = rdata. It stays stable until the next read completes.
- ready, combinational:
  - 0 when req=1 and state≠DONE.
  - 1 in DONE, and whenever req=0.
- Latency: a memory op presented in cycle t keeps ready=0 for cycles t..t+2·WAIT_CYCLES and gives ready=1 in cycle t+2·WAIT_CYCLES+1 (WAIT_CYCLES=5 → 11 stall cycles).
- Non-memory instructions: zero latency, ready=1, no SRAM activity.
- Back-to-back memory ops:
  - The DONE→IDLE edge coincides with EXE/MEM loading the next instruction.
  - The next access starts from IDLE; there is no double access of the previous op.
- Idle SRAM outputs: SRAM_WE_N=1, SRAM_DQ_oe=0. SRAM_ADDR holds the last value (0 after reset).
- Inputs are held stable by the freeze during an access. A change mid-access is illegal; the behaviour is undefined but must not hang the FSM.
- Reset (async, any time, including mid-access):
  - state=IDLE, cnt=0, rdata=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ_oe=0.
  - A partially completed write leaves the SRAM content unspecified.

Test Plan:
- Non-memory op: WB_en_in=1, R/W=0, ALU_result_in=0x55, Dest_in=3 → outputs mirror the inputs, ready=1 every cycle, SRAM_WE_N=1, SRAM_DQ_oe=0.
- Store: W=1, ALU_result_in=1032, ST_val_in=0xDEADBEEF → ready=0 for 11 cycles.
  - SRAM_ADDR=4 with DQ=0xBEEF, WE_N low for 4 of 5 cycles.
  - Then SRAM_ADDR=5 with DQ=0xDEAD, same WE_N timing.
  - ready=1 in cycle 12; SRAM model holds [4]=0xBEEF, [5]=0xDEAD.
- Load: R=1, ALU_result_in=1032 on the preloaded SRAM → Mem_read_value=0xDEADBEEF in the DONE cycle with ready=1. WB_en=0 during the stall, 1 in DONE.
- Back-to-back: store 0x12345678 @1028, then load @1028 → exactly two 11-cycle stalls, one SRAM write sequence, load returns 0x12345678.
- Reset mid-access: assert rst during HIGH of a store → state IDLE immediately, WE_N=1, oe=0, ready=1 while req=0. A fresh store afterwards completes normally.
- R and W both high: W=1, R=1, ALU_result_in=1024, ST_val_in=0xA5A55A5A → performs a write of halves 0x5A5A @0 and 0xA5A5 @1; rdata is unchanged.
